// File: rtl/credit_link.sv
// credit_link: serial frame link with credit flow control and a receive FIFO.
// Optional header parity is enabled by defining CREDIT_LINK_PARITY_EN.
module credit_link #(
    parameter int PAYLOAD_W = 24,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int FRAME_W = PAYLOAD_W + 8,
    localparam int FCW = $clog2(FRAME_W)
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 cable_connected,
    input  logic                 data_in,
    output logic                 data_out,
    input  logic [PAYLOAD_W-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [PAYLOAD_W-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 link_up,
    output logic [CW-1:0]        remote_credit,
    output logic                 rx_overflow,
    output logic                 parity_err
);
    typedef enum logic {DOWN, UP} state_t;
    state_t state, state_nx;
    logic [FRAME_W-1:0] tx_sh, rx_sh;
    logic [FCW-1:0] cnt;
    logic [CW-1:0] rc, cp, wp, rp, rc_nx;
    logic [CW:0] rc_sum;
    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [PAYLOAD_W-1:0] rx_pl, tx_pl;
    logic [7:0] hdr_type;
    logic prev_data, dec_v, frame_end, load, send_data, pop, push, full;
    logic dec, dec_idle, dec_data, par_bad, tx_par;

    always_comb begin
        state_nx = cable_connected ? UP : DOWN;
        frame_end = state == UP && cable_connected && cnt == FCW'(FRAME_W - 1);
        load = (state == DOWN && cable_connected) || frame_end;
        send_data = frame_end && tx_valid && rc != '0 && !(prev_data && cp != '0);
        tx_pl = send_data ? tx_data : PAYLOAD_W'(cp);
        rx_pl = rx_sh[FRAME_W-1:8];
`ifdef CREDIT_LINK_PARITY_EN
        tx_par = ^tx_pl;
        hdr_type = {1'b0, rx_sh[6:0]};
        par_bad = ^rx_sh[FRAME_W-1:7];
`else
        tx_par = 1'b0;
        hdr_type = rx_sh[7:0];
        par_bad = 1'b0;
`endif
        dec = dec_v && state == UP && cable_connected;
        dec_idle = dec && !par_bad && hdr_type == 8'h00;
        dec_data = dec && !par_bad && hdr_type == 8'h01;
        rx_valid = wp != rp;
        pop = rx_valid && rx_ready;
        full = (wp - rp) == CW'(DEPTH);
        push = dec_data && (!full || pop);
        // Returned credit saturates before this cycle's DATA load consumes one
        rc_sum = {1'b0, rc} + (dec_idle ? {1'b0, rx_pl[CW-1:0]} : '0);
        rc_nx = (rc_sum > (CW+1)'(DEPTH) ? CW'(DEPTH) : rc_sum[CW-1:0]) - CW'(send_data);
        rx_data = rx_valid ? mem[rp[CW-2:0]] : '0;
        tx_ready = send_data;
        link_up = state == UP;
        data_out = state == UP && tx_sh[FRAME_W-1];
        remote_credit = rc;
    end

    always_ff @(posedge clk) begin
        state <= res ? DOWN : state_nx;
    end

    always_ff @(posedge clk) begin
        if (res || !cable_connected) begin
            tx_sh <= '0;
            rx_sh <= '0;
            cnt <= '0;
            rc <= CW'(DEPTH);
            cp <= '0;
            wp <= '0;
            rp <= '0;
            prev_data <= 1'b0;
            dec_v <= 1'b0;
        end else begin
            tx_sh <= load ? {tx_pl, tx_par, 6'b0, send_data} : tx_sh << 1;
            rx_sh <= state == UP ? {rx_sh[FRAME_W-2:0], data_in} : '0;
            cnt <= (state == UP && !frame_end) ? cnt + 1'b1 : '0;
            rc <= rc_nx;
            cp <= ((load && !send_data) ? '0 : cp) + CW'(pop);
            wp <= wp + CW'(push);
            rp <= rp + CW'(pop);
            prev_data <= load ? send_data : prev_data;
            dec_v <= frame_end;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[CW-2:0]] <= rx_pl;
    end

    always_ff @(posedge clk) begin
        if (res) rx_overflow <= 1'b0;
        else if (dec_data && full && !pop) rx_overflow <= 1'b1;
    end

`ifdef CREDIT_LINK_PARITY_EN
    logic perr;
    always_ff @(posedge clk) begin
        if (res) perr <= 1'b0;
        else if (dec && par_bad) perr <= 1'b1;
    end
    assign parity_err = perr;
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: doc/credit_link.md
CREDIT_LINK -- requirements
Module: credit_link

Interface
REQ-001 Parameter PAYLOAD_W, default 24, payload bits per frame; legal range 8..64.
REQ-002 Parameter DEPTH, default 4, receive FIFO entries; power of two, 2..256; CW = clog2(DEPTH)+1 SHALL be <= PAYLOAD_W.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 res  in  1  reset, synchronous, active-high.
REQ-005 cable_connected  in  1  physical link present.
REQ-006 data_in  in  1  serial receive bit; data_out  out  1  serial transmit bit.
REQ-007 tx_data  in  PAYLOAD_W  transmit payload; tx_valid  in  1  payload offered; tx_ready  out  1  one-cycle pulse, payload accepted.
REQ-008 rx_data  out  PAYLOAD_W  FIFO head; rx_valid  out  1  FIFO not empty; rx_ready  in  1  consumer pops head.
REQ-009 link_up  out  1; remote_credit  out  CW; rx_overflow  out  1 sticky; parity_err  out  1 sticky.

Function
REQ-010 Frame = FRAME_W = PAYLOAD_W+8 bits, sent MSB first: payload[PAYLOAD_W-1:0], then header[7:0]; header 8'h00 = IDLE, 8'h01 = DATA.
REQ-011 Link states DOWN and UP: DOWN->UP the cycle after cable_connected sampled 1; UP->DOWN the cycle after it is sampled 0; link_up = (state==UP).
REQ-012 In DOWN: data_out 0, bit counters 0, FIFO flushed, credit_pending 0, remote_credit DEPTH, tx_ready 0.
REQ-013 Egress: frame loaded on the DOWN->UP edge and whenever egress bit counter == FRAME_W-1; otherwise shift left one bit per cycle; data_out = shift MSB.
REQ-014 Frame choice at load: DATA if tx_valid && remote_credit!=0 && !(previous frame DATA && credit_pending!=0); else IDLE with payload = zero-extended credit_pending.
REQ-015 DATA load: tx_ready pulses that cycle; remote_credit decrements by 1.
REQ-016 IDLE load carrying P: credit_pending <= credit_pending - P + (pop this cycle); the first frame after DOWN->UP is IDLE with P = 0.
REQ-017 Ingress: in UP, data_in shifted in every cycle, counter aligned to egress counter; frame complete when counter == FRAME_W-1; decode the following cycle.
REQ-018 Decoded IDLE: remote_credit += payload[CW-1:0], saturating at DEPTH; upper payload bits ignored.
REQ-019 Decoded DATA: payload pushed to FIFO, visible on rx_data/rx_valid the cycle after decode; if FIFO full, frame dropped, rx_overflow set.
REQ-020 Other header values: frame discarded, no state change.
REQ-021 FIFO pop when rx_valid && rx_ready; credit_pending +1 per pop; simultaneous push and pop on full FIFO SHALL accept the push.
REQ-022 Simultaneous IDLE decode and DATA load: remote_credit = old + returned - 1 in one update.
REQ-023 cable_connected dropping mid-frame: partial frames discarded, no push, no credit update.

Reset
REQ-024 res high: state DOWN, data_out 0, tx_ready 0, rx_valid 0, rx_data 0, link_up 0, remote_credit DEPTH, credit_pending 0, rx_overflow 0, parity_err 0.
REQ-025 Sticky flags clear only on res.

Configuration
REQ-026 Macro CREDIT_LINK_PARITY_EN defined: header[7] transmitted as even parity over payload; header type compared on header[6:0]; mismatch -> frame discarded, parity_err set.
REQ-027 Macro undefined: header[7] transmitted 0, full 8-bit header compared, parity_err tied 0.

Verification
REQ-028 Loopback (data_out->data_in), defaults, cable 0->1 -> link_up after 1 cycle, first frame IDLE 0x000000_00, remote_credit 4.
REQ-029 Loopback, tx 0xA5A5A5 valid, rx_ready 1 -> tx_ready pulse, rx_data 0xA5A5A5 with rx_valid one cycle after frame decode, remote_credit 4->3->4 after returned IDLE.
REQ-030 Loopback, rx_ready 0, tx_valid held, 6 payloads -> exactly 4 DATA frames sent, remote_credit 0, no rx_overflow.
REQ-031 External driver injects DATA frame into full FIFO -> frame dropped, rx_overflow 1 until res.
REQ-032 cable_connected 0 at bit 10 of a DATA frame -> no push, link_up 0 next cycle, remote_credit 4, FIFO empty.
REQ-033 With CREDIT_LINK_PARITY_EN, injected DATA frame with flipped payload bit -> discarded, parity_err 1.
